bus_router: RTL

BUS_ROUTER -- requirements
Module: bus_router

---
 rtl/bus_router.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bus_router.sv
// bus_router: routes one master access at a time to one of four slaves.
//
// Address bits [31:28] select the region. Regions 0..3 map to slaves 0..3;
// regions 4..15 are unmapped and complete at once with FAULT_RDATA.
// A slave that stays not-ready for more than TIMEOUT cycles is abandoned.
// Unmapped and timed-out accesses are logged in a sticky fault record.
//
// Handshake: the master raises i_request with rw/address/wdata stable and
// keeps it high until o_ready. o_ready is a one-cycle pulse with o_rdata
// valid in that cycle. A new access starts only after i_request has been
// seen low. On the slave side, o_s_request is a one-hot level. It stays high
// until the selected slave's i_s_ready is sampled high, or until the timeout
// abort.
//
// Ports:
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_request, i_rw             master request level, 1 = write
//   i_address, i_wdata          master address / write data
//   o_rdata, o_ready            read data, completion pulse
//   o_s_request                 one-hot slave request (bit n = region n)
//   o_s_rw, o_s_address,        registered access copies; the region
//   o_s_wdata                   nibble is stripped from the address
//   i_s_rdata, i_s_ready        packed slave read data / completion
//   i_fault_clear               clears the fault record
//   o_fault, o_fault_address    sticky fault flag, address of first fault
//   o_dbg_state                 current FSM state (debug)
module bus_router #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] FAULT_RDATA = 32'h0000_0000
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_request,
  input  logic         i_rw,
  input  logic [31:0]  i_address,
  input  logic [31:0]  i_wdata,
  output logic [31:0]  o_rdata,
  output logic         o_ready,
  output logic [3:0]   o_s_request,
  output logic         o_s_rw,
  output logic [31:0]  o_s_address,
  output logic [31:0]  o_s_wdata,
  input  logic [127:0] i_s_rdata,
  input  logic [3:0]   i_s_ready,
  input  logic         i_fault_clear,
  output logic         o_fault,
  output logic [31:0]  o_fault_address,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_e        state_q, state_d;
  logic          rw_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    s_req_q, s_req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          fault_q;
  logic [31:0]   fault_addr_q;

  logic          latch_en;
  logic          fault_evt;
  logic [31:0]   fault_evt_addr;
  logic          req_mapped;
  logic [1:0]    sel;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic          timeout_hit;

  // Regions 0..3 have bits [31:30] clear.
  assign req_mapped  = (i_address[31:30] == 2'b00);
  assign sel         = addr_q[29:28];
  assign sel_ready   = i_s_ready[sel];
  assign sel_rdata   = i_s_rdata[{sel, 5'd0} +: 32];
  // The counter holds the number of ACCESS cycles that have already passed
  // without ready. It reaches TIMEOUT on ACCESS cycle TIMEOUT+1, which is
  // the cycle that aborts.
  assign timeout_hit = (cnt_q == TIMEOUT_CNT);

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_request) state_d = req_mapped ? ST_ACCESS : ST_RESPOND;
      ST_ACCESS:  if (sel_ready || timeout_hit) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_RELEASE;
      ST_RELEASE: if (!i_request) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    latch_en       = 1'b0;
    cnt_d          = cnt_q;
    s_req_d        = '0;
    rdata_d        = rdata_q;
    ready_d        = 1'b0;
    fault_evt      = 1'b0;
    fault_evt_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_request) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          if (req_mapped) begin
            s_req_d = 4'b0001 << i_address[29:28];
          end else begin
            rdata_d        = FAULT_RDATA;
            fault_evt      = 1'b1;
            fault_evt_addr = i_address;
          end
        end
      end
      ST_ACCESS: begin
        // Ready has priority over the abort that would happen in the same cycle.
        if (sel_ready) begin
          rdata_d = sel_rdata;
        end else if (timeout_hit) begin
          rdata_d   = FAULT_RDATA;
          fault_evt = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          s_req_d = s_req_q;
        end
      end
      ST_RESPOND: ready_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and fault record
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      s_req_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      s_req_q <= s_req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      if (latch_en) begin
        rw_q    <= i_rw;
        addr_q  <= i_address;
        wdata_q <= i_wdata;
      end
      // A fault that arrives together with a clear is recorded as a new first fault.
      if (fault_evt && (!fault_q || i_fault_clear)) begin
        fault_q      <= 1'b1;
        fault_addr_q <= fault_evt_addr;
      end else if (i_fault_clear) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign o_rdata         = rdata_q;
  assign o_ready         = ready_q;
  assign o_s_request     = s_req_q;
  assign o_s_rw          = rw_q;
  assign o_s_address     = {4'h0, addr_q[27:0]};
  assign o_s_wdata       = wdata_q;
  assign o_fault         = fault_q;
  assign o_fault_address = fault_addr_q;
  assign o_dbg_state     = state_q;

endmodule
